// File: rtl/pico_ctrl.sv
// pico_ctrl: fetch/decode sequencer for the picoMips accumulator core.
// Holds the PC, addresses synchronous program memory, decodes each
// instruction into ALU / register-file controls, and handles branch,
// WAIT (Go handshake) and HALT.
module pico_ctrl #(
    parameter int unsigned PC_WIDTH = 6,
    parameter int unsigned RA_WIDTH = 3
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [15:0]         Instr,
    input  logic [7:0]          ACC,
    input  logic                Go,
    output logic [PC_WIDTH-1:0] PCAddr,
    output logic [7:0]          Imm,
    output logic                WE,
    output logic                SelImm,
    output logic                SelSW,
    output logic                SelRegData,
    output logic                UseMul,
    output logic                UseACC,
    output logic [RA_WIDTH-1:0] RegAddr,
    output logic                RegWE,
    output logic                Halted
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WAITST,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_LDR  = 4'd2,
        OP_LDS  = 4'd3,
        OP_ADDI = 4'd4,
        OP_ADDR = 4'd5,
        OP_MULI = 4'd6,
        OP_STR  = 4'd7,
        OP_JMP  = 4'd8,
        OP_BZ   = 4'd9,
        OP_BNZ  = 4'd10,
        OP_WAIT = 4'd11,
        OP_HALT = 4'd12
    } op_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt, pc_inc, target;
    op_t                 op;

    assign op      = op_t'(Instr[15:12]);
    assign pc_inc  = pc + PC_WIDTH'(1);
    assign target  = Instr[PC_WIDTH-1:0];
    assign PCAddr  = pc;
    assign RegAddr = Instr[8+RA_WIDTH-1:8];

    // Register-field bits above RA_WIDTH are don't-care.
    generate
        if (RA_WIDTH < 4) begin : g_unused_reg_bits
            logic unused_reg_bits;
            assign unused_reg_bits = ^Instr[11:8+RA_WIDTH];
        end
    endgenerate

    // State and program counter register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= FETCH;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next-state, next-PC and decoded control outputs.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        Imm        = '0;
        WE         = 1'b0;
        SelImm     = 1'b0;
        SelSW      = 1'b0;
        SelRegData = 1'b0;
        UseMul     = 1'b0;
        UseACC     = 1'b0;
        RegWE      = 1'b0;
        Halted     = 1'b0;
        case (state)
            FETCH: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = FETCH;
                pc_nxt    = pc_inc;
                Imm       = Instr[7:0];
                case (op)
                    OP_LDI:  begin WE = 1'b1; SelImm = 1'b1; end
                    OP_LDR:  begin WE = 1'b1; SelRegData = 1'b1; end
                    OP_LDS:  begin WE = 1'b1; SelSW = 1'b1; end
                    OP_ADDI: begin WE = 1'b1; SelImm = 1'b1; UseACC = 1'b1; end
                    OP_ADDR: begin WE = 1'b1; SelRegData = 1'b1; UseACC = 1'b1; end
                    OP_MULI: begin WE = 1'b1; UseMul = 1'b1; UseACC = 1'b1; end
                    OP_STR:  RegWE = 1'b1;
                    OP_JMP:  pc_nxt = target;
                    OP_BZ:   if (ACC == '0) pc_nxt = target;
                    OP_BNZ:  if (ACC != '0) pc_nxt = target;
                    OP_WAIT: begin
                        if (!Go) begin
                            state_nxt = WAITST;
                            pc_nxt    = pc;
                        end
                    end
                    OP_HALT: begin
                        state_nxt = HALT;
                        pc_nxt    = pc;
                    end
                    default: ;
                endcase
            end
            WAITST: begin
                if (Go) begin
                    state_nxt = FETCH;
                    pc_nxt    = pc_inc;
                end
            end
            HALT: begin
                Halted = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

endmodule
